// File: rtl/uart_rx_gen2_if.sv
// uart_rx_gen2 consumer-side bundle: received word, valid/ready handshake
// and one-cycle status pulses.
interface uart_rx_gen2_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  data_ready;
  logic                  PAR_ERR;
  logic                  STP_ERR;
  logic                  OVERRUN;
  logic                  BREAK;

  modport master (
    output P_DATA,
    output data_valid,
    input  data_ready,
    output PAR_ERR,
    output STP_ERR,
    output OVERRUN,
    output BREAK
  );

  modport slave (
    input  P_DATA,
    input  data_valid,
    output data_ready,
    input  PAR_ERR,
    input  STP_ERR,
    input  OVERRUN,
    input  BREAK
  );
endinterface

// File: rtl/uart_rx_gen2.sv
// Oversampling UART receiver: 2-of-3 vote, parity, 1/2 stop, holding reg.
// Define UART_RX_BREAK_EN to report all-zero frames on BREAK.
module uart_rx_gen2 #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] PRESCALE,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  input  logic               STOP2,
  output logic               BUSY,
  uart_rx_gen2_if.master     rx_if
);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [PRESC_W-1:0] ONE   = PRESC_W'(1);
  localparam logic [PRESC_W-1:0] EIGHT = PRESC_W'(8);
  localparam logic [BW-1:0] B1    = BW'(1);
  localparam logic [BW-1:0] LASTD = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_HI
  } state_e;

  state_e state_q, state_d;
  logic [1:0] sync_q;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic [PRESC_W-1:0] p_q, p_d;
  logic [BW-1:0] bit_q, bit_d;
  logic pen_q, pen_d;
  logic ptyp_q, ptyp_d;
  logic stop2_q, stop2_d;
  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic par_bad_q, par_bad_d;
  logic stp_bad_q, stp_bad_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic dv_q, dv_d;
  logic perr_q, perr_d;
  logic serr_q, serr_d;
  logic ovr_q, ovr_d;
  logic brk_q, brk_d;

  logic rx_s;
  logic [PRESC_W-1:0] half;
  logic [PRESC_W-1:0] p_even;
  logic [PRESC_W-1:0] p_eff;
  logic vote;
  logic at_vote;
  logic stp_now;
  logic brk_hit;

  assign rx_s    = sync_q[1];
  assign half    = p_q >> 1;
  assign p_even  = PRESCALE & ~ONE;
  assign p_eff   = (p_even < EIGHT) ? EIGHT : p_even;
  assign vote    = (s1_q & s2_q) | (s1_q & rx_s)
                 | (s2_q & rx_s);
  assign at_vote = (cnt_q == half + ONE);
  assign stp_now = stp_bad_q | ~vote;

`ifdef UART_RX_BREAK_EN
  // Cleared by any 1 seen in a data or parity slot.
  logic zero_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      zero_q <= 1'b0;
    else if (state_q == IDLE)
      zero_q <= 1'b1;
    else if (at_vote && vote &&
             (state_q == DATA || state_q == PARITY))
      zero_q <= 1'b0;
  end
  assign brk_hit = zero_q & stp_now;
`else
  assign brk_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    bit_d     = bit_q;
    pen_d     = pen_q;
    ptyp_d    = ptyp_q;
    stop2_d   = stop2_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    sh_d      = sh_q;
    par_bad_d = par_bad_q;
    stp_bad_d = stp_bad_q;
    data_d    = data_q;
    dv_d      = dv_q & ~rx_if.data_ready;
    perr_d    = 1'b0;
    serr_d    = 1'b0;
    ovr_d     = 1'b0;
    brk_d     = 1'b0;
    if (state_q != IDLE && state_q != WAIT_HI) begin
      cnt_d = (cnt_q == p_q - ONE) ? '0 : cnt_q + ONE;
      if (cnt_q == half - ONE) s1_d = rx_s;
      if (cnt_q == half) s2_d = rx_s;
    end
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d   = START;
          cnt_d     = ONE;
          p_d       = p_eff;
          pen_d     = PAR_EN;
          ptyp_d    = PAR_TYP;
          stop2_d   = STOP2;
          bit_d     = '0;
          par_bad_d = 1'b0;
          stp_bad_d = 1'b0;
        end
      end
      START: begin
        if (at_vote) begin
          bit_d = '0;
          if (vote) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (at_vote) begin
          sh_d = {vote, sh_q[DATA_WIDTH-1:1]};
          if (bit_q == LASTD) begin
            bit_d   = '0;
            state_d = pen_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + B1;
          end
        end
      end
      PARITY: begin
        if (at_vote) begin
          par_bad_d = vote ^ (^sh_q) ^ ptyp_q;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (at_vote) begin
          stp_bad_d = stp_now;
          if (bit_q == BW'(stop2_q)) begin
            cnt_d   = '0;
            state_d = (vote && !brk_hit) ? IDLE : WAIT_HI;
            if (brk_hit) begin
              brk_d = 1'b1;
            end else if (!par_bad_q && !stp_now) begin
              // Transfer in the same cycle frees the register.
              if (!dv_q || rx_if.data_ready) begin
                data_d = sh_q;
                dv_d   = 1'b1;
              end else begin
                ovr_d = 1'b1;
              end
            end else begin
              perr_d = par_bad_q;
              serr_d = stp_now;
            end
          end else begin
            bit_d = bit_q + B1;
          end
        end
      end
      WAIT_HI: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      sync_q    <= 2'b11;
      cnt_q     <= '0;
      p_q       <= EIGHT;
      bit_q     <= '0;
      pen_q     <= 1'b0;
      ptyp_q    <= 1'b0;
      stop2_q   <= 1'b0;
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      sh_q      <= '0;
      par_bad_q <= 1'b0;
      stp_bad_q <= 1'b0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[0], RX_IN};
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      bit_q     <= bit_d;
      pen_q     <= pen_d;
      ptyp_q    <= ptyp_d;
      stop2_q   <= stop2_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      sh_q      <= sh_d;
      par_bad_q <= par_bad_d;
      stp_bad_q <= stp_bad_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      perr_q    <= perr_d;
      serr_q    <= serr_d;
      ovr_q     <= ovr_d;
      brk_q     <= brk_d;
    end
  end

  assign BUSY             = (state_q != IDLE);
  assign rx_if.P_DATA     = data_q;
  assign rx_if.data_valid = dv_q;
  assign rx_if.PAR_ERR    = perr_q;
  assign rx_if.STP_ERR    = serr_q;
  assign rx_if.OVERRUN    = ovr_q;
  assign rx_if.BREAK      = brk_q;
endmodule
